// File: rtl/pad_attr_pkg.sv
// Shared types and helpers for the runtime pad attribute controller.
// Holds the pad type enum, the attribute word layout, the FSM state
// encoding and the per-type legalization (WARL) function.
package pad_attr_pkg;

   localparam int AttrW = 8;

   typedef enum int {
      PadTypeNone  = 0,
      PadTypeBidir = 1,
      PadTypeInput = 2
   } pad_type_e;

   typedef struct packed {
      logic [2:0] drive;
      logic       slew;
      logic       keeper;
      logic       pull_sel;
      logic       pull_en;
      logic       invert;
   } pad_attr_t;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StResp
   } pad_attr_state_e;

   // Input-only pads have no output driver, so drive strength and slew
   // are meaningless and read back as zero; unused pads hold nothing.
   function automatic pad_attr_t legalize(input pad_type_e pad_type,
                                          input pad_attr_t attr);
      pad_attr_t res;
      res = attr;
      case (pad_type)
         PadTypeInput: begin
            res.drive = '0;
            res.slew  = 1'b0;
         end
         PadTypeNone: res = '0;
         default: ;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pad_attr_settle_cnt.sv
// Loadable down-counter timing the settle window after an attribute
// write. done_o flags the last settle cycle (count == 1).
module pad_attr_settle_cnt #(
   parameter int CntW = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic [CntW-1:0] load_val_i,
   input  logic            dec_i,
   output logic            done_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Load wins over decrement; the count saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/pad_attr_ctrl.sv
// Runtime-programmable pad attribute controller. Attributes are
// written/read over a req/gnt/rvalid bus, legalized per pad type, and
// each write holds its pad in a settle window before it is acknowledged.
// Optional macro PAD_ATTR_PARITY_EN adds a per-pad even-parity bit and a
// sticky parity_err_o output.
module pad_attr_ctrl
   import pad_attr_pkg::*;
#(
   parameter int        NumPads      = 16,
   parameter pad_type_e PadType      = PadTypeBidir,
   parameter int        SettleCycles = 4,
   parameter pad_attr_t ResetAttr    = '0,
   parameter int        IdxW         = (NumPads > 1) ? $clog2(NumPads) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_i,
   input  logic                     we_i,
   input  logic [IdxW-1:0]          idx_i,
   input  logic [AttrW-1:0]         wdata_i,
   output logic                     gnt_o,
   output logic                     rvalid_o,
   output logic [AttrW-1:0]         rdata_o,
   output logic                     err_o,
   output logic [NumPads*AttrW-1:0] attr_o,
   output logic [NumPads-1:0]       settling_o
`ifdef PAD_ATTR_PARITY_EN
   ,
   output logic                     parity_err_o
`endif
);

   localparam pad_attr_t     ResetVal  = legalize(PadType, ResetAttr);
   localparam logic [IdxW:0] PadCnt    = (IdxW+1)'(NumPads);
   localparam logic [7:0]    SettleVal = 8'(SettleCycles);

   pad_attr_state_e state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            err_q, err_d;
   pad_attr_t       attr_q [NumPads];
   pad_attr_t       wr_val, rd_sel;
   logic            idx_oor, store, cnt_load, cnt_dec, cnt_done;

   assign idx_oor = ({1'b0, idx_i} >= PadCnt);
   assign wr_val  = legalize(PadType, pad_attr_t'(wdata_i));

   pad_attr_settle_cnt #(
      .CntW(8)
   ) u_settle_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (SettleVal),
      .dec_i      (cnt_dec),
      .done_o     (cnt_done)
   );

   // Next-state logic: accept in IDLE only; out-of-range or reads go
   // straight to the response, writes settle first (unless zero-length).
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      err_d    = err_q;
      gnt_o    = 1'b0;
      store    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         StIdle: begin
            gnt_o = req_i;
            if (req_i) begin
               idx_d = idx_i;
               err_d = idx_oor;
               if (idx_oor || !we_i) begin
                  state_d = StResp;
               end else begin
                  store = 1'b1;
                  if (SettleCycles == 0) begin
                     state_d = StResp;
                  end else begin
                     cnt_load = 1'b1;
                     state_d  = StSettle;
                  end
               end
            end
         end
         StSettle: begin
            cnt_dec = 1'b1;
            if (cnt_done) state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM and latched-access registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Attribute storage; only the addressed in-range pad is written.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < NumPads; p++) attr_q[p] <= ResetVal;
      end else begin
         for (int p = 0; p < NumPads; p++) begin
            if (store && (idx_i == IdxW'(p))) attr_q[p] <= wr_val;
         end
      end
   end

   // Read mux over the latched index; an unmatched index yields zero.
   always_comb begin
      rd_sel = '0;
      for (int p = 0; p < NumPads; p++) begin
         if (idx_q == IdxW'(p)) rd_sel = attr_q[p];
      end
   end

   assign rvalid_o = (state_q == StResp);
   assign err_o    = rvalid_o && err_q;
   assign rdata_o  = (rvalid_o && !err_q) ? rd_sel : '0;

   for (genvar p = 0; p < NumPads; p++) begin : g_pad
      assign attr_o[p*AttrW +: AttrW] = attr_q[p];
      assign settling_o[p] = (state_q == StSettle) && (idx_q == IdxW'(p));
   end

`ifdef PAD_ATTR_PARITY_EN
   logic [NumPads-1:0] par_q;
   logic               par_err_q, par_mis;

   // Recompute every stored word's parity against its stored bit.
   always_comb begin
      par_mis = 1'b0;
      for (int p = 0; p < NumPads; p++) begin
         if ((^attr_q[p]) != par_q[p]) par_mis = 1'b1;
      end
   end

   // Parity bits track writes; the error flag is sticky until reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         par_q     <= {NumPads{^ResetVal}};
         par_err_q <= 1'b0;
      end else begin
         for (int p = 0; p < NumPads; p++) begin
            if (store && (idx_i == IdxW'(p))) par_q[p] <= ^wr_val;
         end
         if (par_mis) par_err_q <= 1'b1;
      end
   end

   assign parity_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Bench for pad_attr_ctrl. Two instances: DUT0 is a 12-pad bidir block
// with a 4-cycle settle (so indices 12..15 are out of range), DUT1 is a
// 16-pad input-only block with zero settle and all-ones reset attributes.
module tb_pad_attr_ctrl;
   import pad_attr_pkg::*;

   localparam int NP0 = 12;
   localparam int NP1 = 16;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]      req, we;
   logic [1:0][3:0] idx;
   logic [1:0][7:0] wdata;
   logic [1:0]      gnt, rvalid, err;
   logic [1:0][7:0] rdata;
   logic [NP0*8-1:0] attr0;
   logic [NP1*8-1:0] attr1;
   logic [NP0-1:0]   st0;
   logic [NP1-1:0]   st1;

   int nvec = 0;
   int nerr = 0;
   int np[2]     = '{NP0, NP1};
   int settle[2] = '{4, 0};
   logic [7:0] mem [2][16];

   always #5 clk = ~clk;

   pad_attr_ctrl #(
      .NumPads(NP0), .PadType(PadTypeBidir), .SettleCycles(4), .ResetAttr(8'h3C)
   ) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .idx_i(idx[0]),
      .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
      .err_o(err[0]), .attr_o(attr0), .settling_o(st0)
   );

   pad_attr_ctrl #(
      .NumPads(NP1), .PadType(PadTypeInput), .SettleCycles(0), .ResetAttr(8'hFF)
   ) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .idx_i(idx[1]),
      .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
      .err_o(err[1]), .attr_o(attr1), .settling_o(st1)
   );

   // Reference rules: input-only pads keep only the low nibble
   // (keeper, pull_sel, pull_en, invert); bidir pads keep everything.
   function automatic logic [7:0] ref_legal(input int s, input logic [7:0] v);
      return (s == 1) ? (v & 8'h0F) : v;
   endfunction

   function automatic logic [7:0] get_attr(input int s, input int p);
      if (s == 0) return attr0[p*8 +: 8];
      return attr1[p*8 +: 8];
   endfunction

   function automatic logic [15:0] get_settl(input int s);
      return (s == 0) ? {4'b0, st0} : st1;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 16; p++) begin
         mem[0][p] = 8'h3C;
         mem[1][p] = 8'h0F;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_attrs(input int s);
      for (int p = 0; p < np[s]; p++)
         chk($sformatf("attr%0d[%0d]", s, p), get_attr(s, p), mem[s][p]);
   endtask

   // One complete bus access on DUT s, starting in an IDLE cycle.
   // Junk is driven during the busy cycles to show inputs are ignored.
   task automatic access(input int s, input bit w, input int i, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit exp_err);
      bit oor;
      int lat;
      logic [15:0] exp_st;
      oor = (i >= np[s]);
      lat = (oor || !w) ? 1 : settle[s] + 1;
      req[s] = 1'b1; we[s] = w; idx[s] = 4'(i); wdata[s] = d;
      #1 chk("gnt_idle", gnt[s], 1);
      if (w && !oor) mem[s][i] = ref_legal(s, d);
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         req[s] = (c < lat); we[s] = 1'($urandom); idx[s] = 4'($urandom); wdata[s] = 8'($urandom);
         #1;
         exp_st = (w && !oor && c <= settle[s]) ? (16'd1 << i) : 16'd0;
         chk("gnt_busy", gnt[s], 0);
         chk("rvalid", rvalid[s], (c == lat) ? 1 : 0);
         chk("settling", get_settl(s), exp_st);
         chk("rdata", rdata[s], (c == lat) ? exp_rd : 8'h00);
         chk("err", err[s], (c == lat) ? exp_err : 1'b0);
         if (c == 1) check_attrs(s);
      end
      req[s] = 1'b0;
      @(posedge clk); #1;
      chk("rvalid_idle", rvalid[s], 0);
   endtask

   typedef struct {
      int         s;
      bit         w;
      int         i;
      logic [7:0] d;
      logic [7:0] rd;
      bit         er;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int s, i, w;
      logic [7:0] d, er;
      bit oor;

      tbl[0]  = '{0, 1'b0,  3, 8'h00, 8'h3C, 1'b0};
      tbl[1]  = '{0, 1'b1,  3, 8'hE5, 8'hE5, 1'b0};
      tbl[2]  = '{0, 1'b0,  3, 8'h00, 8'hE5, 1'b0};
      tbl[3]  = '{0, 1'b0, 13, 8'h00, 8'h00, 1'b1};
      tbl[4]  = '{0, 1'b1, 15, 8'hAA, 8'h00, 1'b1};
      tbl[5]  = '{0, 1'b1, 11, 8'h5A, 8'h5A, 1'b0};
      tbl[6]  = '{0, 1'b1,  3, 8'hE5, 8'hE5, 1'b0};
      tbl[7]  = '{1, 1'b1,  3, 8'hE5, 8'h05, 1'b0};
      tbl[8]  = '{1, 1'b0,  3, 8'h00, 8'h05, 1'b0};
      tbl[9]  = '{1, 1'b1, 15, 8'hFF, 8'h0F, 1'b0};
      tbl[10] = '{1, 1'b0,  0, 8'h00, 8'h0F, 1'b0};
      tbl[11] = '{0, 1'b1,  0, 8'h00, 8'h00, 1'b0};

      rst = 1'b1; req = '0; we = '0; idx = '0; wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_attrs(0);
      check_attrs(1);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_rvalid", rvalid[k], 0);
         chk("rst_err", err[k], 0);
         chk("rst_rdata", rdata[k], 0);
         chk("rst_settling", get_settl(k), 0);
         chk("rst_gnt_lo", gnt[k], 0);
      end
      req = 2'b11;
      #1 chk("rst_gnt_hi0", gnt[0], 1);
      chk("rst_gnt_hi1", gnt[1], 1);
      req = 2'b00;
      #1;

      // Directed table.
      for (int n = 0; n < 12; n++)
         access(tbl[n].s, tbl[n].w, tbl[n].i, tbl[n].d, tbl[n].rd, tbl[n].er);

      // Reset during the settle window of a DUT0 write.
      req[0] = 1'b1; we[0] = 1'b1; idx[0] = 4'd3; wdata[0] = 8'h77;
      #1 chk("ab_gnt", gnt[0], 1);
      @(posedge clk); #1;
      req[0] = 1'b0;
      #1 chk("ab_settling", get_settl(0), 16'h0008);
      chk("ab_attr3", get_attr(0, 3), 8'h77);
      @(posedge clk); #1;
      rst = 1'b1;
      #1 model_reset();
      check_attrs(0);
      check_attrs(1);
      chk("ab_settling_rst", get_settl(0), 0);
      chk("ab_rvalid_rst", rvalid[0], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         chk("ab_no_rvalid0", rvalid[0], 0);
         chk("ab_no_rvalid1", rvalid[1], 0);
         chk("ab_no_settle", get_settl(0), 0);
      end
      access(0, 1'b0, 3, 8'h00, 8'h3C, 1'b0);

      // Zero-settle write then read with req held high on DUT1.
      req[1] = 1'b1; we[1] = 1'b1; idx[1] = 4'd5; wdata[1] = 8'hE5;
      #1 chk("b2b_gnt_w", gnt[1], 1);
      chk("b2b_rv_T", rvalid[1], 0);
      mem[1][5] = 8'h05;
      @(posedge clk); #1;
      we[1] = 1'b0;
      #1 chk("b2b_rv_T1", rvalid[1], 1);
      chk("b2b_rd_T1", rdata[1], 8'h05);
      chk("b2b_err_T1", err[1], 0);
      chk("b2b_gnt_T1", gnt[1], 0);
      chk("b2b_attr5", get_attr(1, 5), 8'h05);
      @(posedge clk); #2;
      chk("b2b_gnt_T2", gnt[1], 1);
      chk("b2b_rv_T2", rvalid[1], 0);
      @(posedge clk); #1;
      req[1] = 1'b0;
      #1 chk("b2b_rv_T3", rvalid[1], 1);
      chk("b2b_rd_T3", rdata[1], 8'h05);
      @(posedge clk); #2;
      chk("b2b_rv_T4", rvalid[1], 0);

      // Randomized accesses against the model.
      for (int n = 0; n < 60; n++) begin
         s   = int'($urandom_range(0, 1));
         w   = int'($urandom_range(0, 1));
         i   = int'($urandom_range(0, 15));
         d   = 8'($urandom);
         oor = (i >= np[s]);
         er  = oor ? 8'h00 : ((w != 0) ? ref_legal(s, d) : mem[s][i]);
         access(s, w != 0, i, d, er, oor);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
